// File: rtl/cpu_mem_arbiter.sv
// Arbitrates one SRAM-like memory port between instruction fetch and load/store.
// Data accesses win; each access completes once per pipeline advance.
module cpu_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_en,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_stall,
    input  logic                data_en,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_stall,
    input  logic                pipeline_stall,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, D_ADDR, D_WAIT, I_ADDR, I_WAIT} state_t;

    state_t              state_q, state_d;
    logic                inst_done_q, inst_done_d;
    logic                data_done_q, data_done_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_wr_q, mem_wr_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
    logic                inst_set, data_set;

    assign inst_stall = inst_en & ~inst_done_q;
    assign data_stall = data_en & ~data_done_q;

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_wr_d     = mem_wr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_set     = 1'b0;
        data_set     = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_en && !data_done_q) begin
                    mem_req_d   = 1'b1;
                    mem_wr_d    = |data_wen;
                    mem_wstrb_d = data_wen;
                    mem_addr_d  = data_addr;
                    mem_wdata_d = data_wdata;
                    state_d     = D_ADDR;
                end else if (inst_en && !inst_done_q) begin
                    mem_req_d   = 1'b1;
                    mem_wr_d    = 1'b0;
                    mem_wstrb_d = '0;
                    mem_addr_d  = inst_addr;
                    state_d     = I_ADDR;
                end
            end
            D_ADDR, I_ADDR: begin
                if (mem_addr_ok) begin
                    mem_req_d = 1'b0;
                    state_d   = (state_q == D_ADDR) ? D_WAIT : I_WAIT;
                end
            end
            D_WAIT: begin
                if (mem_data_ok) begin
                    data_set = 1'b1;
                    if (!mem_wr_q) data_rdata_d = mem_rdata;
                    state_d = IDLE;
                end
            end
            I_WAIT: begin
                if (mem_data_ok) begin
                    inst_set     = 1'b1;
                    inst_rdata_d = mem_rdata;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An advancing pipeline clears both flags even if an access finishes on the same edge.
        inst_done_d = pipeline_stall & (inst_done_q | inst_set);
        data_done_d = pipeline_stall & (data_done_q | data_set);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wstrb_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            mem_req_q    <= mem_req_d;
            mem_wr_q     <= mem_wr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_wr     = mem_wr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: CPU-side driver, memory responder and a scoreboard
// monitor that checks issued requests and completed read data against a queue model.
module tb_cpu_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_en, data_en, ext_stall;
    logic [AW-1:0] inst_addr, data_addr;
    logic [SW-1:0] data_wen;
    logic [DW-1:0] data_wdata;
    logic [DW-1:0] inst_rdata, data_rdata;
    logic          inst_stall, data_stall, pipeline_stall;
    logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [SW-1:0] mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    assign pipeline_stall = inst_stall | data_stall | ext_stall;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_stall(inst_stall),
        .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_stall(data_stall), .pipeline_stall(pipeline_stall),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic          wr;
        logic [SW-1:0] strb;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [DW-1:0] irdata;
        logic [DW-1:0] drdata;
    } cmp_t;

    req_t          exp_req_q[$];
    cmp_t          exp_cmp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            fixed_bp = -1;
    int            fixed_lat = -1;
    logic [DW-1:0] model_i = '0;
    logic [DW-1:0] model_d = '0;

    // Memory contents: a fixed function of the address, with the boot word pinned.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C08_BFAF;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    endtask

    // Memory responder: drives its handshake 1 time unit after each falling edge.
    initial begin : responder
        logic          pending, prev_rst, bp_set, r_wr;
        int            wait_cnt, bp_cnt;
        logic [AW-1:0] r_addr;
        pending = 1'b0; prev_rst = 1'b1; bp_set = 1'b0; r_wr = 1'b0;
        wait_cnt = 0; bp_cnt = 0; r_addr = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (prev_rst) begin
                pending = 1'b0;
                bp_set  = 1'b0;
            end else if (mem_addr_ok) begin
                pending  = 1'b1;
                wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            mem_rdata   = $urandom;
            prev_rst    = rst;
            if (!rst) begin
                if (pending) begin
                    if (wait_cnt == 0) begin
                        mem_data_ok = 1'b1;
                        pending     = 1'b0;
                        if (!r_wr) mem_rdata = mem_word(r_addr);
                    end else begin
                        wait_cnt--;
                    end
                end else if (mem_req) begin
                    if (!bp_set) begin
                        bp_cnt = (fixed_bp >= 0) ? fixed_bp : int'($urandom_range(0, 2));
                        bp_set = 1'b1;
                    end
                    if (bp_cnt == 0) begin
                        mem_addr_ok = 1'b1;
                        bp_set      = 1'b0;
                        r_addr      = mem_addr;
                        r_wr        = mem_wr;
                    end else begin
                        bp_cnt--;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: samples 2 time units after each falling edge.
    initial begin : monitor
        logic          hold, h_wr;
        logic [SW-1:0] h_strb;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_wdata;
        req_t          e;
        cmp_t          c;
        hold = 1'b0; h_wr = 1'b0; h_strb = '0; h_addr = '0; h_wdata = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("req_held", 64'(mem_req), 64'(1'b1));
                    check("held_addr", 64'(mem_addr), 64'(h_addr));
                    check("held_wdata", 64'(mem_wdata), 64'(h_wdata));
                    check("held_wr_strb", 64'({mem_wr, mem_wstrb}), 64'({h_wr, h_strb}));
                end
                if (mem_req && mem_addr_ok) begin
                    if (exp_req_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_req: addr %0h issued, none expected", mem_addr);
                    end else begin
                        e = exp_req_q.pop_front();
                        check("req_wr", 64'(mem_wr), 64'(e.wr));
                        check("req_strb", 64'(mem_wstrb), 64'(e.strb));
                        check("req_addr", 64'(mem_addr), 64'(e.addr));
                        if (e.wr) check("req_wdata", 64'(mem_wdata), 64'(e.wdata));
                    end
                end
                if ((inst_en || data_en) && !pipeline_stall) begin
                    if (exp_cmp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_completion: no completion expected");
                    end else begin
                        c = exp_cmp_q.pop_front();
                        check("inst_rdata", 64'(inst_rdata), 64'(c.irdata));
                        check("data_rdata", 64'(data_rdata), 64'(c.drdata));
                    end
                end
                hold    = mem_req && !mem_addr_ok;
                h_wr    = mem_wr;
                h_strb  = mem_wstrb;
                h_addr  = mem_addr;
                h_wdata = mem_wdata;
            end
        end
    end

    // One CPU step: called at a falling edge, returns at the falling edge where the next step may start.
    task automatic do_step(input logic ie, input logic [AW-1:0] ia, input logic de,
                           input logic [SW-1:0] dw, input logic [AW-1:0] da,
                           input logic [DW-1:0] dd, input int ext_n, input bit rst_mode,
                           input int exp_lat);
        req_t rd, ri;
        cmp_t c;
        int   cyc;
        bit   ok;
        inst_en = ie; inst_addr = ia;
        data_en = de; data_wen = dw; data_addr = da; data_wdata = dd;
        ext_stall = 1'b0;
        rd = '{|dw, dw, da, dd};
        ri = '{1'b0, {SW{1'b0}}, ia, {DW{1'b0}}};
        if (de) begin
            exp_req_q.push_back(rd);
            if (dw == '0) model_d = mem_word(da);
        end
        if (ie) begin
            exp_req_q.push_back(ri);
            model_i = mem_word(ia);
        end
        if (rst_mode) begin
            cyc = 0;
            while (!mem_req && cyc < 50) begin @(negedge clk); cyc++; end
            while (mem_req && cyc < 100) begin @(negedge clk); cyc++; end
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rst_mem_req", 64'(mem_req), 64'(0));
            check("rst_mem_wr", 64'(mem_wr), 64'(0));
            check("rst_mem_wstrb", 64'(mem_wstrb), 64'(0));
            check("rst_mem_addr", 64'(mem_addr), 64'(0));
            check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
            check("rst_inst_rdata", 64'(inst_rdata), 64'(0));
            check("rst_data_rdata", 64'(data_rdata), 64'(0));
            check("rst_data_stall", 64'(data_stall), 64'(de));
            model_i = '0;
            if (de) exp_req_q.push_back(rd);
            if (ie) exp_req_q.push_back(ri);
            fixed_lat = 1;
        end
        c.irdata = model_i;
        c.drdata = model_d;
        exp_cmp_q.push_back(c);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (!inst_stall && !data_stall) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL step_timeout: stalls still high after %0d cycles, expected release", cyc);
            finish_run();
        end
        if (exp_lat > 0) check("stall_latency", 64'(cyc), 64'(exp_lat));
        if (ext_n > 0) begin
            ext_stall = 1'b1;
            repeat (ext_n) @(negedge clk);
            ext_stall = 1'b0;
        end
        @(negedge clk);
        if (ie) check("inst_done_clear", 64'(inst_stall), 64'(1));
        if (de) check("data_done_clear", 64'(data_stall), 64'(1));
    endtask

    initial begin : watchdog
        #2_000_000;
        n_cmp++; n_err++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        finish_run();
    end

    initial begin : main
        logic          ie, de;
        logic [SW-1:0] dw;
        int            ext_n;
        rst = 1'b1; ext_stall = 1'b0;
        inst_en = 1'b0; inst_addr = '0;
        data_en = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_mem_req", 64'(mem_req), 64'(0));
        check("reset_mem_wr", 64'(mem_wr), 64'(0));
        check("reset_mem_wstrb", 64'(mem_wstrb), 64'(0));
        check("reset_mem_addr", 64'(mem_addr), 64'(0));
        check("reset_mem_wdata", 64'(mem_wdata), 64'(0));
        check("reset_inst_rdata", 64'(inst_rdata), 64'(0));
        check("reset_data_rdata", 64'(data_rdata), 64'(0));
        @(negedge clk);

        // Directed cases with deterministic memory timing.
        fixed_bp = 0; fixed_lat = 1;
        do_step(1'b1, 32'hBFC0_0000, 1'b0, 4'b0000, 32'h0, 32'h0, 0, 1'b0, 4);
        do_step(1'b1, 32'hBFC0_0004, 1'b1, 4'b0000, 32'h8000_1000, 32'h0, 0, 1'b0, 8);
        do_step(1'b0, 32'h0, 1'b1, 4'b0011, 32'h8000_1004, 32'h1234_ABCD, 0, 1'b0, 4);
        do_step(1'b1, 32'hBFC0_0008, 1'b0, 4'b0000, 32'h0, 32'h0, 5, 1'b0, 4);
        fixed_bp = 4;
        do_step(1'b0, 32'h0, 1'b1, 4'b1111, 32'h8000_2000, 32'hDEAD_BEEF, 0, 1'b0, 8);
        fixed_bp = 0; fixed_lat = 30;
        do_step(1'b1, 32'hBFC0_000C, 1'b0, 4'b0000, 32'h0, 32'h0, 0, 1'b0, 0);
        do_step(1'b0, 32'h0, 1'b1, 4'b0000, 32'h8000_3000, 32'h0, 0, 1'b1, 0);

        // Randomized traffic with random backpressure and latency.
        fixed_bp = -1; fixed_lat = -1;
        for (int i = 0; i < 150; i++) begin
            ie = ($urandom_range(0, 9) < 8);
            de = $urandom_range(0, 1) == 1;
            if (!ie && !de) ie = 1'b1;
            dw = ($urandom_range(0, 1) == 1) ? SW'($urandom_range(1, 15)) : '0;
            ext_n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_step(ie, $urandom & 32'hFFFF_FFFC, de, dw, $urandom & 32'hFFFF_FFFC,
                    $urandom, ext_n, 1'b0, 0);
        end

        inst_en = 1'b0; data_en = 1'b0;
        repeat (5) @(negedge clk);
        check("req_queue_empty", 64'(exp_req_q.size()), 64'(0));
        check("cmp_queue_empty", 64'(exp_cmp_q.size()), 64'(0));
        finish_run();
    end
endmodule
